// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory request/data/response channel between icache (m0) and dcache (m1)
module mem_arbiter #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int TAG_BITS   = 5,
  parameter int DATA_BEATS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m0_req_valid,
  output logic                   m0_req_ready,
  input  logic                   m0_req_rw,
  input  logic [ADDR_BITS-1:0]   m0_req_addr,
  input  logic [TAG_BITS-2:0]    m0_req_tag,
  input  logic                   m0_req_data_valid,
  output logic                   m0_req_data_ready,
  input  logic [DATA_BITS-1:0]   m0_req_data_bits,
  input  logic [DATA_BITS/8-1:0] m0_req_data_mask,
  output logic                   m0_resp_valid,
  output logic [TAG_BITS-2:0]    m0_resp_tag,
  output logic [DATA_BITS-1:0]   m0_resp_data,
  input  logic                   m1_req_valid,
  output logic                   m1_req_ready,
  input  logic                   m1_req_rw,
  input  logic [ADDR_BITS-1:0]   m1_req_addr,
  input  logic [TAG_BITS-2:0]    m1_req_tag,
  input  logic                   m1_req_data_valid,
  output logic                   m1_req_data_ready,
  input  logic [DATA_BITS-1:0]   m1_req_data_bits,
  input  logic [DATA_BITS/8-1:0] m1_req_data_mask,
  output logic                   m1_resp_valid,
  output logic [TAG_BITS-2:0]    m1_resp_tag,
  output logic [DATA_BITS-1:0]   m1_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_rw,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic [TAG_BITS-1:0]    mem_req_tag,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [TAG_BITS-1:0]    mem_resp_tag,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);
  localparam int CW = DATA_BEATS > 1 ? $clog2(DATA_BEATS) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WDATA} state_t;
  state_t state, state_n;
  logic g, g_n, p, p_n, k, req_on, dat_on, req_fire, dat_fire, last;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      g     <= 1'b0;
      p     <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      g     <= g_n;
      p     <= p_n;
      cnt   <= cnt_n;
    end
  // outputs are forced quiet while reset is held, whatever the registered state
  assign req_on = state == REQ && !reset;
  assign dat_on = state == WDATA && !reset;
  assign mem_req_valid = req_on && (g ? m1_req_valid : m0_req_valid);
  assign mem_req_rw    = g ? m1_req_rw : m0_req_rw;
  assign mem_req_addr  = g ? m1_req_addr : m0_req_addr;
  assign mem_req_tag   = {g, g ? m1_req_tag : m0_req_tag};
  assign m0_req_ready  = req_on && !g && mem_req_ready;
  assign m1_req_ready  = req_on && g && mem_req_ready;
  assign mem_req_data_valid = dat_on && (g ? m1_req_data_valid : m0_req_data_valid);
  assign mem_req_data_bits  = g ? m1_req_data_bits : m0_req_data_bits;
  assign mem_req_data_mask  = g ? m1_req_data_mask : m0_req_data_mask;
  assign m0_req_data_ready  = dat_on && !g && mem_req_data_ready;
  assign m1_req_data_ready  = dat_on && g && mem_req_data_ready;
  assign req_fire = mem_req_valid && mem_req_ready;
  assign dat_fire = mem_req_data_valid && mem_req_data_ready;
  assign last     = cnt == CW'(DATA_BEATS - 1);
  // responses are routed purely by the tag MSB, independent of the arbitration state
  assign k             = mem_resp_tag[TAG_BITS-1];
  assign m0_resp_valid = mem_resp_valid && !k && !reset;
  assign m1_resp_valid = mem_resp_valid && k && !reset;
  assign m0_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign m1_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign m0_resp_data  = mem_resp_data;
  assign m1_resp_data  = mem_resp_data;
  always_comb begin
    state_n = state;
    g_n     = g;
    p_n     = p;
    cnt_n   = cnt;
    case (state)
      IDLE: if (m0_req_valid || m1_req_valid) begin
        g_n     = m0_req_valid && m1_req_valid ? p : m1_req_valid;
        state_n = REQ;
      end
      REQ: if (req_fire) begin
        state_n = mem_req_rw ? WDATA : IDLE;
        p_n     = mem_req_rw ? p : !g;
        cnt_n   = '0;
      end
      WDATA: if (dat_fire) begin
        cnt_n   = last ? '0 : cnt + CW'(1);
        state_n = last ? IDLE : WDATA;
        p_n     = last ? !g : p;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized masters checked against a transaction-level arbitration model
module tb_mem_arbiter;
  localparam int AB = 28, DB = 128, TB = 5, NB = 4;
  typedef struct packed {
    logic          rw;
    logic [AB-1:0] addr;
    logic [TB-2:0] tag;
    logic [NB*DB-1:0]   data;
    logic [NB*DB/8-1:0] mask;
  } txn_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] v, rw, dv, rdy, drdy, rv;
  logic [AB-1:0] ad [2];
  logic [TB-2:0] tg [2];
  logic [DB-1:0] db [2];
  logic [DB/8-1:0] dm [2];
  logic [TB-2:0] rt0, rt1;
  logic [DB-1:0] rd0, rd1;
  logic mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready, mem_resp_valid;
  logic [AB-1:0] mem_req_addr;
  logic [TB-1:0] mem_req_tag, mem_resp_tag;
  logic [DB-1:0] mem_req_data_bits, mem_resp_data;
  logic [DB/8-1:0] mem_req_data_mask;
  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req_valid(v[0]), .m0_req_ready(rdy[0]), .m0_req_rw(rw[0]), .m0_req_addr(ad[0]), .m0_req_tag(tg[0]),
    .m0_req_data_valid(dv[0]), .m0_req_data_ready(drdy[0]), .m0_req_data_bits(db[0]), .m0_req_data_mask(dm[0]),
    .m0_resp_valid(rv[0]), .m0_resp_tag(rt0), .m0_resp_data(rd0),
    .m1_req_valid(v[1]), .m1_req_ready(rdy[1]), .m1_req_rw(rw[1]), .m1_req_addr(ad[1]), .m1_req_tag(tg[1]),
    .m1_req_data_valid(dv[1]), .m1_req_data_ready(drdy[1]), .m1_req_data_bits(db[1]), .m1_req_data_mask(dm[1]),
    .m1_resp_valid(rv[1]), .m1_resp_tag(rt1), .m1_resp_data(rd1),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
  );
  int total = 0, bad = 0;
  task automatic chk(input string t, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic quiet(input string t);
    chk(t, {mem_req_valid, mem_req_data_valid, rdy, drdy, rv}, 8'h00);
  endtask
  task automatic idle_inputs;
    v = 0; rw = 0; dv = 0;
    for (int i = 0; i < 2; i++) begin
      ad[i] = '0; tg[i] = '0; db[i] = '0; dm[i] = '0;
    end
    mem_req_ready = 0; mem_req_data_ready = 0;
    mem_resp_valid = 0; mem_resp_tag = '0; mem_resp_data = '0;
  endtask
  logic [DB-1:0] dd [NB];
  int got, sent, m0g;
  logic rf, f;
  // random-phase state: masters' agents and the arbitration reference model
  txn_t q0[$], q1[$], cur[2], h, wtx;
  int bz[2], bt[2], ph, wb, done;
  logic gr, ls;
  logic [1:0] fr, fd;
  initial begin
    for (int i = 0; i < NB; i++) dd[i] = {4{32'hD000_0000 + 32'(i)}};
    idle_inputs();
    // single m0 read
    tick;
    v[0] = 1; ad[0] = 28'h100; tg[0] = 4'd3; mem_req_ready = 1;
    mid; quiet("reset_outputs");
    tick; reset = 0;
    mid; quiet("t1_idle");
    tick;
    mid; chk("t1_req", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag, rdy}, {1'b1, 1'b0, 28'h100, 5'b00011, 2'b01});
    tick; v[0] = 0;
    mid; chk("t1_after", mem_req_valid, 0);
    // both masters reading continuously alternate
    reset = 1; tick; reset = 0;
    v = 2'b11; tg[0] = 4'd1; tg[1] = 4'd2; ad[0] = 28'h10; ad[1] = 28'h20;
    for (int i = 0, e = 0; i < 8; i++) begin
      mid;
      if (i % 2 == 1) begin
        chk("t2_tag", {mem_req_valid, mem_req_tag, mem_req_addr}, e ? {1'b1, 5'h12, 28'h20} : {1'b1, 5'h01, 28'h10});
        e ^= 1;
      end else chk("t2_idle", mem_req_valid, 0);
      tick;
    end
    // m1 write burst with toggling data ready, m0 waiting
    v = 0; reset = 1; tick; reset = 0;
    v[1] = 1; rw[1] = 1; ad[1] = 28'h2340; tg[1] = 4'd5; dv[1] = 1; db[1] = dd[0]; dm[1] = 16'hFFFF;
    mem_req_ready = 1; mem_req_data_ready = 1;
    got = 0; sent = 0; m0g = 0;
    for (int c = 0; c < 40 && got < NB; c++) begin
      mid;
      if (rdy[0]) m0g++;
      if (mem_req_data_valid && mem_req_data_ready) begin
        chk("t3_beat", {mem_req_data_bits, mem_req_data_mask}, {dd[got], 16'hFFFF});
        got++;
      end
      rf = rdy[1] && v[1];
      f = drdy[1] && dv[1];
      tick;
      if (rf) begin
        v[1] = 0; v[0] = 1; rw[0] = 0; ad[0] = 28'h500; tg[0] = 4'd9;
      end
      if (f) begin
        sent++; dv[1] = sent < NB; db[1] = dd[sent % NB];
      end
      mem_req_data_ready = ~mem_req_data_ready;
    end
    chk("t3_beats", got, NB);
    chk("t3_m0_blocked", m0g, 0);
    mid; chk("t3_idle", mem_req_valid, 0);
    tick;
    mid; chk("t3_m0_req", {mem_req_valid, mem_req_tag, mem_req_addr}, {1'b1, 5'h09, 28'h500});
    tick; v[0] = 0;
    // response routing
    mem_resp_valid = 1; mem_resp_tag = 5'b10111; mem_resp_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    mid;
    chk("t4_m1_valid", rv, 2'b10);
    chk("t4_m1_tag", rt1, 4'b0111);
    chk("t4_data", {rd0, rd1}, {2{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}});
    tick; mem_resp_tag = 5'b00101;
    mid; chk("t4_m0", {rv, rt0}, {2'b01, 4'b0101});
    tick; mem_resp_valid = 0;
    mid; chk("t4_none", rv, 2'b00);
    // reset in the middle of a write burst
    v[1] = 1; rw[1] = 1; ad[1] = 28'h3000; tg[1] = 4'd6; dv[1] = 1; db[1] = dd[0];
    mem_req_ready = 1; mem_req_data_ready = 1;
    got = 0; sent = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      mid;
      if (mem_req_data_valid && mem_req_data_ready) got++;
      rf = rdy[1] && v[1];
      f = drdy[1] && dv[1];
      tick;
      if (rf) v[1] = 0;
      if (f) begin
        sent++; db[1] = dd[sent % NB];
      end
    end
    chk("t5_two_beats", got, 2);
    reset = 1;
    mid; quiet("t5_in_reset");
    tick; reset = 0;
    mid; quiet("t5_idle");
    tick; dv = 0; v[0] = 1; rw[0] = 0; ad[0] = 28'h700; tg[0] = 4'd4;
    mid; chk("t5_arb", mem_req_valid, 0);
    tick;
    mid; chk("t5_read", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag, rdy}, {1'b1, 1'b0, 28'h700, 5'h04, 2'b01});
    tick; idle_inputs();
    // randomized traffic against the reference model
    reset = 1; tick; reset = 0;
    ph = 0; ls = 1; gr = 0; done = 0; wb = 0;
    bz = '{0, 0}; bt = '{0, 0};
    for (int c = 0; c < 3000; c++) begin
      mid;
      chk("rsp_valid", rv, mem_resp_valid ? (mem_resp_tag[TB-1] ? 2'b10 : 2'b01) : 2'b00);
      chk("rsp_tag", mem_resp_tag[TB-1] ? rt1 : rt0, mem_resp_tag[TB-2:0]);
      chk("rsp_data", {rd0, rd1}, {2{mem_resp_data}});
      fr = rdy & v;
      fd = drdy & dv;
      if (ph == 0) begin
        chk("idle", {mem_req_valid, mem_req_data_valid, rdy, drdy}, 6'h00);
        if (|v) begin
          gr = &v ? !ls : v[1];
          ph = 1;
        end
      end else if (ph == 1) begin
        if ((gr ? q1.size() : q0.size()) == 0) chk("queue_empty", 1, 0);
        else begin
          h = gr ? q1[0] : q0[0];
          chk("req", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag, rdy, mem_req_data_valid, drdy},
              {1'b1, h.rw, h.addr, gr, h.tag, gr ? {mem_req_ready, 1'b0} : {1'b0, mem_req_ready}, 1'b0, 2'b00});
          if (mem_req_valid && mem_req_ready) begin
            if (gr) void'(q1.pop_front()); else void'(q0.pop_front());
            if (h.rw) begin
              wtx = h; wb = 0; ph = 2;
            end else begin
              ls = gr; ph = 0; done++;
            end
          end
        end
      end else begin
        chk("wdata", {mem_req_valid, mem_req_data_valid, rdy, drdy},
            {1'b0, dv[gr], 2'b00, gr ? {mem_req_data_ready, 1'b0} : {1'b0, mem_req_data_ready}});
        if (mem_req_data_valid && mem_req_data_ready) begin
          chk("beat", {mem_req_data_bits, mem_req_data_mask}, {wtx.data[wb*DB +: DB], wtx.mask[wb*DB/8 +: DB/8]});
          wb++;
          if (wb == NB) begin
            ls = gr; ph = 0; done++;
          end
        end
      end
      tick;
      for (int i = 0; i < 2; i++) begin
        if (fr[i]) begin
          v[i] = 0; bz[i] = cur[i].rw ? 2 : 0;
        end
        if (fd[i]) begin
          bt[i]++;
          if (bt[i] == NB) bz[i] = 0;
        end
        if (bz[i] == 0) begin
          dv[i] = 0;
          if ($urandom_range(0, 2) == 0) begin
            cur[i].rw = 1'($urandom_range(0, 1));
            cur[i].addr = AB'($urandom);
            cur[i].tag = (TB-1)'($urandom);
            for (int w = 0; w < NB*DB/32; w++) cur[i].data[w*32 +: 32] = $urandom;
            cur[i].mask = {$urandom, $urandom};
            if (i == 0) q0.push_back(cur[i]); else q1.push_back(cur[i]);
            bz[i] = 1; bt[i] = 0; v[i] = 1;
            rw[i] = cur[i].rw; ad[i] = cur[i].addr; tg[i] = cur[i].tag;
          end
        end
        if (bz[i] != 0 && cur[i].rw && !(dv[i] && !fd[i])) begin
          dv[i] = $urandom_range(0, 2) != 0;
          db[i] = cur[i].data[bt[i]*DB +: DB];
          dm[i] = cur[i].mask[bt[i]*DB/8 +: DB/8];
        end
      end
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_req_data_ready = 1'($urandom_range(0, 1));
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_tag = TB'($urandom);
      mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
    end
    chk("progress", done > 50, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
